// File: rtl/hazard_scoreboard_if.sv
// ID/EX hazard-control bundle between the pipeline (master) and the scoreboard unit (slave).
interface hazard_scoreboard_if #(parameter int REG_ADDR_W = 4);
  logic [REG_ADDR_W-1:0] rs1_ID, rs2_ID, rd_EX;
  logic                  Read_Enable_1_ID, Read_Enable_2_ID;
  logic                  Write_Enable_EX, I_Type_EX, Mem_WR_EX;
  logic                  Is_Address_Taken;
  logic                  Do_Stall;
  logic [1:0]            MUX_IF_PM;
  logic                  MUX_ID_PM;

  modport master (
    output rs1_ID, rs2_ID, rd_EX, Read_Enable_1_ID, Read_Enable_2_ID,
           Write_Enable_EX, I_Type_EX, Mem_WR_EX, Is_Address_Taken,
    input  Do_Stall, MUX_IF_PM, MUX_ID_PM
  );

  modport slave (
    input  rs1_ID, rs2_ID, rd_EX, Read_Enable_1_ID, Read_Enable_2_ID,
           Write_Enable_EX, I_Type_EX, Mem_WR_EX, Is_Address_Taken,
    output Do_Stall, MUX_IF_PM, MUX_ID_PM
  );
endinterface

// File: rtl/hazard_scoreboard_unit.sv
// Multi-cycle load-use hazard scoreboard driving IF/ID and ID/EX register muxes.
// Optional STALL_PERF_CNT_EN adds saturating stall/flush cycle counters.
module hazard_scoreboard_unit #(
  parameter int REG_ADDR_W = 4,
  parameter int LOAD_LAT   = 1,
  parameter int R0_IS_ZERO = 0,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef STALL_PERF_CNT_EN
  output logic [CNT_W-1:0]  Stall_Count,
  output logic [CNT_W-1:0]  Flush_Count,
`endif
  hazard_scoreboard_if.slave hs
);
  localparam int NREG = 1 << REG_ADDR_W;
  localparam int BW   = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;
  localparam logic [BW-1:0] LOAD_INIT = BW'(LOAD_LAT - 1);

  logic [BW-1:0] busy [NREG];
  logic          load_EX, hz1, hz2, stall;

  assign load_EX = hs.Write_Enable_EX & hs.I_Type_EX & ~hs.Mem_WR_EX;

  // The load in EX covers its own cycle; the counter covers the LOAD_LAT-1 that follow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) busy[r] <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (load_EX && hs.rd_EX == REG_ADDR_W'(r)) busy[r] <= LOAD_INIT;
        else if (busy[r] != '0)                    busy[r] <= busy[r] - BW'(1);
      end
    end
  end

  assign hz1 = !((R0_IS_ZERO != 0) && hs.rs1_ID == '0) &&
               ((load_EX && hs.rs1_ID == hs.rd_EX) || busy[hs.rs1_ID] != '0);
  assign hz2 = !((R0_IS_ZERO != 0) && hs.rs2_ID == '0) &&
               ((load_EX && hs.rs2_ID == hs.rd_EX) || busy[hs.rs2_ID] != '0);

  // Outputs are forced inactive while reset is held, whatever the inputs do.
  assign stall       = rst_n & ((hs.Read_Enable_1_ID & hz1) | (hs.Read_Enable_2_ID & hz2));
  assign hs.Do_Stall = stall;

  always_comb begin
    hs.MUX_IF_PM = 2'b00;
    hs.MUX_ID_PM = 1'b0;
    if (rst_n && hs.Is_Address_Taken) begin
      hs.MUX_IF_PM = 2'b01;
      hs.MUX_ID_PM = 1'b1;
    end else if (stall) begin
      hs.MUX_IF_PM = 2'b10;
      hs.MUX_ID_PM = 1'b1;
    end
  end

`ifdef STALL_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Stall_Count <= '0;
      Flush_Count <= '0;
    end else begin
      if (stall && !hs.Is_Address_Taken && Stall_Count != '1) Stall_Count <= Stall_Count + CNT_W'(1);
      if (hs.Is_Address_Taken && Flush_Count != '1)           Flush_Count <= Flush_Count + CNT_W'(1);
    end
  end
`endif
endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed bench: three scoreboard configurations share one stimulus stream.
module tb_hazard_scoreboard_unit;
  logic clk = 1'b0;
  logic rst_n;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  hazard_scoreboard_if #(.REG_ADDR_W(4)) if1 ();
  hazard_scoreboard_if #(.REG_ADDR_W(4)) if3 ();
  hazard_scoreboard_if #(.REG_ADDR_W(4)) ifz ();

`ifdef STALL_PERF_CNT_EN
  logic [15:0] sc1, fc1, sc3, fc3, scz, fcz;
`endif

  hazard_scoreboard_unit #(.REG_ADDR_W(4), .LOAD_LAT(1), .R0_IS_ZERO(0), .CNT_W(16)) dut1 (
    .clk(clk), .rst_n(rst_n),
`ifdef STALL_PERF_CNT_EN
    .Stall_Count(sc1), .Flush_Count(fc1),
`endif
    .hs(if1));
  hazard_scoreboard_unit #(.REG_ADDR_W(4), .LOAD_LAT(3), .R0_IS_ZERO(0), .CNT_W(16)) dut3 (
    .clk(clk), .rst_n(rst_n),
`ifdef STALL_PERF_CNT_EN
    .Stall_Count(sc3), .Flush_Count(fc3),
`endif
    .hs(if3));
  hazard_scoreboard_unit #(.REG_ADDR_W(4), .LOAD_LAT(3), .R0_IS_ZERO(1), .CNT_W(16)) dutz (
    .clk(clk), .rst_n(rst_n),
`ifdef STALL_PERF_CNT_EN
    .Stall_Count(scz), .Flush_Count(fcz),
`endif
    .hs(ifz));

  // Expected output codes {MUX_IF_PM, MUX_ID_PM, Do_Stall}
  localparam logic [3:0] N  = 4'b0000;
  localparam logic [3:0] S  = 4'b1011;
  localparam logic [3:0] F1 = 4'b0111;
  localparam logic [3:0] F0 = 4'b0110;

  task automatic drive(input logic [3:0] rs1, input logic [3:0] rs2, input logic re1, input logic re2,
                       input logic [3:0] rd, input logic we, input logic it, input logic mw, input logic tk);
    if1.rs1_ID = rs1; if1.rs2_ID = rs2; if1.Read_Enable_1_ID = re1; if1.Read_Enable_2_ID = re2;
    if1.rd_EX = rd; if1.Write_Enable_EX = we; if1.I_Type_EX = it; if1.Mem_WR_EX = mw; if1.Is_Address_Taken = tk;
    if3.rs1_ID = rs1; if3.rs2_ID = rs2; if3.Read_Enable_1_ID = re1; if3.Read_Enable_2_ID = re2;
    if3.rd_EX = rd; if3.Write_Enable_EX = we; if3.I_Type_EX = it; if3.Mem_WR_EX = mw; if3.Is_Address_Taken = tk;
    ifz.rs1_ID = rs1; ifz.rs2_ID = rs2; ifz.Read_Enable_1_ID = re1; ifz.Read_Enable_2_ID = re2;
    ifz.rd_EX = rd; ifz.Write_Enable_EX = we; ifz.I_Type_EX = it; ifz.Mem_WR_EX = mw; ifz.Is_Address_Taken = tk;
  endtask

  // Advance one cycle and apply the new inputs 1 time unit after the edge.
  task automatic cyc(input logic [3:0] rs1, input logic [3:0] rs2, input logic re1, input logic re2,
                     input logic [3:0] rd, input logic we, input logic it, input logic mw, input logic tk);
    @(posedge clk); #1;
    drive(rs1, rs2, re1, re2, rd, we, it, mw, tk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk(input string tag, input logic [3:0] e1, input logic [3:0] e3, input logic [3:0] ez);
    chk1({tag, "/lat1"}, {if1.MUX_IF_PM, if1.MUX_ID_PM, if1.Do_Stall}, e1);
    chk1({tag, "/lat3"}, {if3.MUX_IF_PM, if3.MUX_ID_PM, if3.Do_Stall}, e3);
    chk1({tag, "/r0z"},  {ifz.MUX_IF_PM, ifz.MUX_ID_PM, ifz.Do_Stall}, ez);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(4'd5, 4'd5, 1'b1, 1'b1, 4'd5, 1'b1, 1'b1, 1'b0, 1'b1);
    #2 chk("reset_forced", N, N, N);
    drive(4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1 rst_n = 1'b1;
    cyc(4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("idle", N, N, N);

    // Load rd=5, consumer reads rs1=5
    cyc(4'd5, 4'd0, 1'b1, 1'b0, 4'd5, 1'b1, 1'b1, 1'b0, 1'b0); chk("ldA_t0", S, S, S);
    cyc(4'd5, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0); chk("ldA_t1", N, S, S);
    cyc(4'd5, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0); chk("ldA_t2", N, S, S);
    cyc(4'd5, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0); chk("ldA_t3", N, N, N);

    // Load rd=7, consumer reads rs2=7
    cyc(4'd0, 4'd7, 1'b0, 1'b1, 4'd7, 1'b1, 1'b1, 1'b0, 1'b0); chk("ldB_t0", S, S, S);
    cyc(4'd0, 4'd7, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0); chk("ldB_t1", N, S, S);
    cyc(4'd7, 4'd7, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0); chk("ldB_t2_re", N, S, S);
    cyc(4'd0, 4'd7, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0); chk("ldB_noread", N, N, N);

    // Back-to-back loads to rd=2: newest restarts the count
    cyc(4'd2, 4'd0, 1'b1, 1'b0, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0); chk("ldC_t0", S, S, S);
    cyc(4'd2, 4'd0, 1'b1, 1'b0, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0); chk("ldC_t1", S, S, S);
    cyc(4'd2, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0); chk("ldC_t2", N, S, S);
    cyc(4'd2, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0); chk("ldC_t3", N, S, S);
    cyc(4'd2, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0); chk("ldC_t4", N, N, N);

    // Taken branch during stall on rd=4
    cyc(4'd4, 4'd0, 1'b1, 1'b0, 4'd4, 1'b1, 1'b1, 1'b0, 1'b0); chk("brD_t0", S, S, S);
    cyc(4'd4, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1); chk("brD_flush", F0, F1, F1);
    cyc(4'd4, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0); chk("brD_resume", N, S, S);
    cyc(4'd4, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0); chk("brD_clear", N, N, N);

    // Register 0 loads and non-load writes
    cyc(4'd0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0); chk("r0_t0", S, S, N);
    cyc(4'd0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0); chk("r0_t1", N, S, N);
    cyc(4'd0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0); chk("r0_t2", N, S, N);
    cyc(4'd0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0); chk("r0_t3", N, N, N);
    cyc(4'd3, 4'd3, 1'b1, 1'b1, 4'd3, 1'b1, 1'b1, 1'b1, 1'b0); chk("store_rd3", N, N, N);
    cyc(4'd3, 4'd3, 1'b1, 1'b1, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0); chk("rtype_rd3", N, N, N);
    cyc(4'd3, 4'd3, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0); chk("rd3_after", N, N, N);

    // Reset asserted mid-stall
    cyc(4'd6, 4'd0, 1'b1, 1'b0, 4'd6, 1'b1, 1'b1, 1'b0, 1'b0); chk("rstF_t0", S, S, S);
    cyc(4'd6, 4'd0, 1'b1, 1'b0, 4'd6, 1'b1, 1'b1, 1'b0, 1'b1); chk("rstF_flush", F1, F1, F1);
    rst_n = 1'b0; #1;
    chk("rstF_async", N, N, N);
    @(posedge clk); #1;
    chk("rstF_held", N, N, N);
    drive(4'd6, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1; #1;
    chk("rstF_release", N, N, N);
    cyc(4'd6, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0); chk("rstF_after", N, N, N);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
